shift_rot_sched: RTL
====================

SHIFT_ROT_SCHED -- requirements
Module: shift_rot_sched

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width in bits.
REQ-002 Parameter: AW, default $clog2(WIDTH), rotate-amount width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports below are in the order listed.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 a_valid, b_valid  in  1 each  requester A/B has a rotate job.
REQ-007 a_ready, b_ready  out  1 each  job accepted on this edge when valid&&ready.
REQ-008 a_data, b_data  in  WIDTH each  operand.
REQ-009 a_amt, b_amt  in  AW each  rotate distance, 0..WIDTH-1.
REQ-010 a_dir, b_dir  in  1 each  0 = rotate left, 1 = rotate right.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_data  out  WIDTH  rotated result.
REQ-014 out_id  out  1  source of result, 0 = A, 1 = B.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ROT and DONE; only one job is in flight at a time.
REQ-017 Arbitration SHALL be round-robin via a last_grant register; when both requesters are valid, grant the one not granted last; when one is valid, grant it.
REQ-018 In IDLE, the granted port's ready SHALL be high combinationally; the other ready SHALL be low; both readies SHALL be low outside IDLE.
REQ-019 On accept, the block SHALL capture data, amt, dir and id, update last_grant, and go to DONE if amt==0, else to ROT with cnt=amt.
REQ-020 In ROT, each cycle SHALL rotate the working register by exactly 1 bit in the captured direction (no bits lost) and decrement cnt; on the cycle cnt==1 it SHALL go to DONE.
REQ-021 Latency: out_valid SHALL first assert amt+1 clocks after the accept edge; result = operand rotated by amt.
REQ-022 In DONE, out_valid SHALL be high and out_data/out_id SHALL be held stable until out_valid&&out_ready; that edge returns to IDLE.
REQ-023 A new job SHALL NOT be accepted on the out handshake edge; minimum spacing between accepts is amt+2 clocks.
REQ-024 Input changes on the non-granted port and during ROT/DONE SHALL NOT affect the in-flight result.
REQ-025 The rotation amount SHALL be treated as unsigned; amt values >= WIDTH (non-power-of-2 WIDTH) SHALL be reduced modulo WIDTH at capture.

Reset
REQ-026 While rst_n is low: state=IDLE, out_valid=0, out_data=0, out_id=0, busy=0, cnt=0, last_grant=B (so A wins the first tie), a_ready=b_ready=0.
REQ-027 Reset asserted mid-ROT or mid-DONE SHALL abort the job immediately with no output handshake; after release, the first tie goes to A.

Verification
REQ-028 A only: a_data=8'h62, a_amt=3, a_dir=0 -> out_valid 4 clocks after accept, out_data=8'h13, out_id=0.
REQ-029 B only: b_data=8'h62, b_amt=1, b_dir=1 -> out_valid 2 clocks after accept, out_data=8'h31, out_id=1; amt=0 case -> out_data=8'h62 after 1 clock.
REQ-030 A and B held valid together after reset -> grants alternate A,B,A,B; no port is granted twice in a row while the other waits.
REQ-031 out_ready held low 5 clocks in DONE -> out_valid, out_data and out_id stable; a_ready=b_ready=0 throughout.
REQ-032 rst_n pulsed low during ROT (a_amt=7) -> out_valid stays 0, busy=0 in the next clock, and the next tie is granted to A.
REQ-033 Sweep amt 0..7 both directions on 8'h62 -> every result matches a reference rotate and the latency matches REQ-021.

Source files
------------

// File: rtl/shift_rot_sched.sv
// Round-robin two-port rotate engine: one job in flight, rotated 1 bit per clock in ROT.
// Result appears amt+1 clocks after accept (counting the accept edge); held in DONE until out_ready.
module shift_rot_sched #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             b_valid,
  output logic             a_ready,
  output logic             b_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [AW-1:0]    a_amt,
  input  logic [AW-1:0]    b_amt,
  input  logic             a_dir,
  input  logic             b_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;

  logic             grant_a, grant_b;
  logic [WIDTH-1:0] sel_data;
  logic [AW-1:0]    sel_amt;
  logic             sel_dir;

  // The amount field can exceed WIDTH-1 only when WIDTH is not a power of two,
  // and then by less than WIDTH, so one conditional subtract is a full modulo.
  function automatic logic [AW-1:0] mod_amt(input logic [AW-1:0] amt);
    if (int'(amt) >= WIDTH) return amt - AW'(WIDTH);
    return amt;
  endfunction

  always_comb begin
    grant_a  = a_valid && (!b_valid || last_grant_q);
    grant_b  = b_valid && (!a_valid || !last_grant_q);
    a_ready  = rst_n && (state_q == IDLE) && grant_a;
    b_ready  = rst_n && (state_q == IDLE) && grant_b;
    sel_data = b_ready ? b_data : a_data;
    sel_amt  = mod_amt(b_ready ? b_amt : a_amt);
    sel_dir  = b_ready ? b_dir : a_dir;
  end

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (a_ready || b_ready) begin
          work_d       = sel_data;
          dir_d        = sel_dir;
          id_d         = b_ready;
          last_grant_d = b_ready;
          cnt_d        = sel_amt;
          state_d      = (sel_amt == '0) ? DONE : ROT;
        end
      end
      ROT: begin
        work_d = dir_q ? {work_q[0], work_q[WIDTH-1:1]}
                       : {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == AW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;
  assign out_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
